// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-clock BRAM with a 1-cycle registered read.
// Optional BRAM_ARB_DUAL_ISSUE_EN: pair a write and a read from different requesters in one cycle.
module bram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] bram_i_addr,
    output logic [DW-1:0] bram_i_data,
    output logic          bram_write,
    output logic [AW-1:0] bram_o_addr,
    output logic          bram_read,
    input  logic [DW-1:0] bram_o_read
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t        state_q;
    logic          prio_q;
    logic          rpend_q;
    logic          rtag_q;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;

    logic dual_ok;
    logic wr_a, wr_b, rd_a, rd_b;

`ifdef BRAM_ARB_DUAL_ISSUE_EN
    assign dual_ok = (a_we != b_we);
`else
    assign dual_ok = 1'b0;
`endif

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (a_req && b_req) begin
                        if (dual_ok) begin
                            a_gnt = 1'b1;
                            b_gnt = 1'b1;
                        end else begin
                            a_gnt = !prio_q;
                            b_gnt = prio_q;
                        end
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
                // Non-owner only rides along with a complementary op of the owner
                OWN_A: begin
                    a_gnt = a_req;
                    b_gnt = b_req && a_req && dual_ok;
                end
                OWN_B: begin
                    b_gnt = b_req;
                    a_gnt = a_req && b_req && dual_ok;
                end
                default: ;
            endcase
        end
    end

    assign wr_a = a_gnt & a_we;
    assign wr_b = b_gnt & b_we;
    assign rd_a = a_gnt & ~a_we;
    assign rd_b = b_gnt & ~b_we;

    assign bram_write  = wr_a | wr_b;
    assign bram_i_addr = wr_a ? a_addr  : (wr_b ? b_addr  : '0);
    assign bram_i_data = wr_a ? a_wdata : (wr_b ? b_wdata : '0);
    assign bram_read   = rd_a | rd_b;
    assign bram_o_addr = rd_a ? a_addr  : (rd_b ? b_addr  : '0);

    // Read data arrives one cycle after the grant; reset drops a return in flight
    assign a_rvalid = rpend_q & ~rtag_q & ~rst;
    assign b_rvalid = rpend_q &  rtag_q & ~rst;
    assign a_rdata  = a_rvalid ? bram_o_read : a_rdata_q;
    assign b_rdata  = b_rvalid ? bram_o_read : b_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            rpend_q   <= 1'b0;
            rtag_q    <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            rpend_q <= rd_a | rd_b;
            rtag_q  <= rd_b;
            if (a_rvalid) a_rdata_q <= bram_o_read;
            if (b_rvalid) b_rdata_q <= bram_o_read;
            unique case (state_q)
                IDLE: begin
                    if (a_gnt ^ b_gnt) prio_q <= a_gnt;
                    if (a_gnt && a_lock)      state_q <= OWN_A;
                    else if (b_gnt && b_lock) state_q <= OWN_B;
                end
                OWN_A:   if (!a_lock) state_q <= IDLE;
                OWN_B:   if (!b_lock) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized bench for bram_arbiter against a cycle-level reference of the arbitration rules.
// Honours BRAM_ARB_DUAL_ISSUE_EN when the design is built with it.
module tb_bram_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
`ifdef BRAM_ARB_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] bram_i_addr, bram_o_addr;
    logic [DW-1:0] bram_i_data, bram_o_read;
    logic          bram_write, bram_read;

    always #5 clk = ~clk;

    bram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .bram_i_addr(bram_i_addr), .bram_i_data(bram_i_data), .bram_write(bram_write),
        .bram_o_addr(bram_o_addr), .bram_read(bram_read), .bram_o_read(bram_o_read)
    );

    // BRAM behaviour: write and registered read on the same edge, read sees old data
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_write) mem[bram_i_addr] <= bram_i_data;
        if (bram_read)  bram_o_read <= mem[bram_o_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: owner 0=none 1=A 2=B; b_first mirrors who wins the next tie
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            owner   = 0;
    bit            b_first = 1'b0;
    bit            pend    = 1'b0;
    bit            pend_b  = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] hold_a = '0, hold_b = '0;
    bit            last_ga = 1'b0, last_gb = 1'b0;

    task automatic step();
        bit ga, gb, wa, wb, ra, rb, differ;
        @(negedge clk);
        differ = DUAL && (a_we != b_we);
        ga = 1'b0; gb = 1'b0;
        if (!rst) begin
            if (owner == 0) begin
                if (a_req && b_req) begin
                    if (differ) begin ga = 1'b1; gb = 1'b1; end
                    else begin ga = !b_first; gb = b_first; end
                end else begin
                    ga = a_req; gb = b_req;
                end
            end else if (owner == 1) begin
                ga = a_req; gb = b_req && a_req && differ;
            end else begin
                gb = b_req; ga = a_req && b_req && differ;
            end
        end
        wa = ga && a_we;  wb = gb && b_we;
        ra = ga && !a_we; rb = gb && !b_we;

        chk("a_gnt", a_gnt, ga);
        chk("b_gnt", b_gnt, gb);
        chk("bram_write", bram_write, wa || wb);
        chk("bram_i_addr", bram_i_addr, wa ? a_addr : (wb ? b_addr : '0));
        chk("bram_i_data", bram_i_data, wa ? a_wdata : (wb ? b_wdata : '0));
        chk("bram_read", bram_read, ra || rb);
        chk("bram_o_addr", bram_o_addr, ra ? a_addr : (rb ? b_addr : '0));
        chk("a_rvalid", a_rvalid, pend && !pend_b && !rst);
        chk("b_rvalid", b_rvalid, pend && pend_b && !rst);
        if (!rst) begin
            chk("a_rdata", a_rdata, (pend && !pend_b) ? pend_data : hold_a);
            chk("b_rdata", b_rdata, (pend && pend_b) ? pend_data : hold_b);
        end

        if (rst) begin
            owner = 0; b_first = 1'b0; pend = 1'b0; pend_b = 1'b0;
            hold_a = '0; hold_b = '0;
        end else begin
            if (pend) begin
                if (pend_b) hold_b = pend_data;
                else        hold_a = pend_data;
            end
            pend      = ra || rb;
            pend_b    = rb;
            pend_data = ref_mem[ra ? a_addr : b_addr];
            if (wa) ref_mem[a_addr] = a_wdata;
            if (wb) ref_mem[b_addr] = b_wdata;
            if (owner == 0) begin
                if (ga != gb) b_first = ga;
                if (ga && a_lock)      owner = 1;
                else if (gb && b_lock) owner = 2;
            end else if (owner == 1) begin
                if (!a_lock) owner = 0;
            end else if (!b_lock) begin
                owner = 0;
            end
        end
        last_ga = ga; last_gb = gb;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input bit req, input bit we, input bit lock, input int addr, input logic [DW-1:0] d);
        a_req = req; a_we = we; a_lock = lock; a_addr = AW'(addr); a_wdata = d;
    endtask

    task automatic set_b(input bit req, input bit we, input bit lock, input int addr, input logic [DW-1:0] d);
        b_req = req; b_we = we; b_lock = lock; b_addr = AW'(addr); b_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        set_a(1, 1, 0, 8'h00, 32'h1111_0000);
        set_b(1, 1, 0, 8'h01, 32'h2222_0001);
        step();
        step();
        rst = 1'b0;
        step();
        step();

        // Fill the region the rest of the run touches
        set_b(0, 0, 0, 0, '0);
        for (int i = 0; i < 64; i++) begin
            set_a(1, 1, 0, i, $urandom);
            step();
        end

        set_a(1, 1, 0, 8'h10, 32'hDEAD_BEEF);
        step();
        set_a(1, 0, 0, 8'h10, '0);
        step();
        set_a(0, 0, 0, 0, '0);
        step();
        chk("a_rdata_hold_deadbeef", a_rdata, 32'hDEAD_BEEF);

        set_a(1, 0, 0, 8'h11, '0);
        set_b(1, 0, 0, 8'h12, '0);
        repeat (4) step();
        set_a(0, 0, 0, 0, '0);
        set_b(0, 0, 0, 0, '0);
        step();

        set_a(1, 0, 1, 8'h13, '0);
        step();
        set_b(1, 0, 0, 8'h14, '0);
        step();
        set_a(1, 0, 0, 8'h15, '0);
        step();
        set_a(0, 0, 0, 0, '0);
        step();
        set_b(0, 0, 0, 0, '0);
        step();

`ifdef BRAM_ARB_DUAL_ISSUE_EN
        set_a(1, 1, 0, 8'h20, 32'h55);
        set_b(1, 0, 0, 8'h20, '0);
        step();
        set_a(0, 0, 0, 0, '0);
        set_b(0, 0, 0, 0, '0);
        step();
`else
        set_a(1, 1, 0, 8'h20, 32'h55);
        step();
        set_a(0, 0, 0, 0, '0);
`endif
        set_b(1, 0, 0, 8'h20, '0);
        step();
        set_b(0, 0, 0, 0, '0);
        step();
        chk("b_rdata_after_write", b_rdata, 32'h55);

        // Read grant followed by reset: the return must be dropped
        set_a(1, 0, 1, 8'h10, '0);
        step();
        set_a(0, 0, 0, 0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_a(1, 0, 0, 8'h11, '0);
        set_b(1, 0, 0, 8'h12, '0);
        step();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!a_req || last_ga)
                set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 63), $urandom);
            if (!b_req || last_gb)
                set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 63), $urandom);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
